// File: rtl/user_uart_rx_pkg.sv
// Shared types and constants for the user UART receiver.
package user_uart_rx_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } rx_state_t;

  localparam logic [31:0] REG_DATA   = 32'h0000_0000;
  localparam logic [31:0] REG_STATUS = 32'h0000_0004;

  localparam int ST_NONEMPTY = 0;
  localparam int ST_OVR      = 1;
  localparam int ST_FERR     = 2;
  localparam int ST_PERR     = 3;

  // Even parity: the parity bit that makes the total count of ones even.
  function automatic logic even_parity(input logic [7:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/user_uart_rx_fifo.sv
// Byte FIFO for received characters; a pop in the same cycle frees a full slot for a push.
module user_uart_rx_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [7:0]                 push_data,
  input  logic                       pop,
  output logic [7:0]                 pop_data,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);
  localparam int AW = $clog2(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push_ok;
  logic          pop_ok;

  assign full     = (count == (AW+1)'(DEPTH));
  assign empty    = (count == '0);
  assign pop_ok   = pop & ~empty;
  assign push_ok  = push & (~full | pop_ok);
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; entries are only read while counted as valid.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/user_uart_rx.sv
// naive_bus slave deserialising i_uart_rx into a byte FIFO (8N1, or 8E1 with USER_UART_RX_PARITY_EN).
// Registers: 0x0 DATA (read pops), 0x4 STATUS (W1C error flags).
module user_uart_rx
  import user_uart_rx_pkg::*;
#(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_uart_rx,
  output logic        o_irq,
  input  logic        rd_req,
  output logic        rd_gnt,
  input  logic [31:0] rd_addr,
  output logic [31:0] rd_data,
  input  logic        wr_req,
  output logic        wr_gnt,
  input  logic [31:0] wr_addr,
  input  logic [31:0] wr_data,
  input  logic [3:0]  wr_be
);
  localparam int BIT_DIV = CLK_FREQ / BAUD;
  localparam int DIV_W   = $clog2(BIT_DIV);
  localparam int CW      = $clog2(FIFO_DEPTH) + 1;
  localparam logic [DIV_W-1:0] HALF_LOAD = DIV_W'(BIT_DIV / 2 - 1);
  localparam logic [DIV_W-1:0] FULL_LOAD = DIV_W'(BIT_DIV - 1);
`ifdef USER_UART_RX_PARITY_EN
  localparam rx_state_t AFTER_DATA = PARITY;
`else
  localparam rx_state_t AFTER_DATA = STOP;
`endif

  logic sync1, sync2, sync3, line, fall;
  rx_state_t state, state_nxt;
  logic [DIV_W-1:0] div_cnt, div_nxt;
  logic [2:0] bit_cnt, bit_nxt;
  logic [7:0] shreg, shreg_nxt;
  logic par_bad, par_bad_nxt, div_done;
  logic rx_push, ferr_set, perr_set;
  logic ovr, ferr, perr;
  logic fifo_pop, fifo_full, fifo_empty;
  logic [7:0] fifo_data;
  logic [CW-1:0] fifo_count;
  logic [31:0] status_word, rd_next;
  logic sel_status_rd, sts_clr, ovr_set;
  logic unused_bus;

  // Two-flop synchroniser plus a third flop for falling-edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      sync3 <= 1'b1;
    end else begin
      sync1 <= i_uart_rx;
      sync2 <= sync1;
      sync3 <= sync2;
    end
  end

  assign line     = sync2;
  assign fall     = sync3 & ~sync2;
  assign div_done = (div_cnt == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      div_cnt <= '0;
      bit_cnt <= 3'd0;
      shreg   <= 8'h00;
      par_bad <= 1'b0;
    end else begin
      state   <= state_nxt;
      div_cnt <= div_nxt;
      bit_cnt <= bit_nxt;
      shreg   <= shreg_nxt;
      par_bad <= par_bad_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    div_nxt     = div_cnt;
    bit_nxt     = bit_cnt;
    shreg_nxt   = shreg;
    par_bad_nxt = par_bad;
    rx_push     = 1'b0;
    ferr_set    = 1'b0;
    perr_set    = 1'b0;
    case (state)
      IDLE: begin
        if (fall) begin
          state_nxt   = START;
          div_nxt     = HALF_LOAD;
          bit_nxt     = 3'd0;
          par_bad_nxt = 1'b0;
        end else begin
          state_nxt = IDLE;
        end
      end
      START: begin
        if (!div_done) begin
          div_nxt = div_cnt - DIV_W'(1);
        end else if (!line) begin
          state_nxt = DATA;
          div_nxt   = FULL_LOAD;
        end else begin
          state_nxt = IDLE;
        end
      end
      DATA: begin
        if (div_done) begin
          shreg_nxt = {line, shreg[7:1]};
          div_nxt   = FULL_LOAD;
          bit_nxt   = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) state_nxt = AFTER_DATA;
          else                 state_nxt = DATA;
        end else begin
          div_nxt = div_cnt - DIV_W'(1);
        end
      end
`ifdef USER_UART_RX_PARITY_EN
      PARITY: begin
        if (div_done) begin
          par_bad_nxt = (even_parity(shreg) != line);
          perr_set    = (even_parity(shreg) != line);
          div_nxt     = FULL_LOAD;
          state_nxt   = STOP;
        end else begin
          div_nxt = div_cnt - DIV_W'(1);
        end
      end
`endif
      STOP: begin
        if (div_done) begin
          state_nxt = IDLE;
          if (line) rx_push  = ~par_bad;
          else      ferr_set = 1'b1;
        end else begin
          div_nxt = div_cnt - DIV_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  user_uart_rx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (rx_push),
    .push_data (shreg),
    .pop       (fifo_pop),
    .pop_data  (fifo_data),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign o_irq         = |fifo_count;
  assign rd_gnt        = rd_req;
  assign wr_gnt        = wr_req;
  assign sel_status_rd = (rd_addr[2] == REG_STATUS[2]);
  assign fifo_pop      = rd_req & ~sel_status_rd & ~fifo_empty;
  assign ovr_set       = rx_push & fifo_full & ~fifo_pop;
  assign sts_clr       = wr_req & (wr_addr[2] == REG_STATUS[2]) & wr_be[0];
  assign status_word   = {28'h0, perr, ferr, ovr, ~fifo_empty};

  always_comb begin
    rd_next = 32'h0;
    if (sel_status_rd)    rd_next = status_word;
    else if (!fifo_empty) rd_next = {23'h0, 1'b1, fifo_data};
    else                  rd_next = 32'h0;
  end

  // Registered read data and sticky error flags; a same-cycle event beats the clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data <= 32'h0;
      ovr     <= 1'b0;
      ferr    <= 1'b0;
      perr    <= 1'b0;
    end else begin
      if (rd_req) rd_data <= rd_next;
      ovr  <= ovr_set  | (ovr  & ~(sts_clr & wr_data[ST_OVR]));
      ferr <= ferr_set | (ferr & ~(sts_clr & wr_data[ST_FERR]));
      perr <= perr_set | (perr & ~(sts_clr & wr_data[ST_PERR]));
    end
  end

  assign unused_bus = ^{rd_addr[31:3], rd_addr[1:0], wr_addr[31:3], wr_addr[1:0],
                        wr_data[31:4], wr_data[0], wr_be[3:1]};

endmodule

// File: tb/tb_user_uart_rx.sv
// Directed scoreboard bench for user_uart_rx; 8E1 frames are sent when USER_UART_RX_PARITY_EN is defined.
module tb_user_uart_rx;
  // A faster line rate keeps the 17-byte overflow run short; half a bit still exceeds the 100-cycle glitch.
  localparam int CLK_FREQ = 50_000_000;
  localparam int BAUD     = 230_400;
  localparam int BIT_DIV  = CLK_FREQ / BAUD;
`ifdef USER_UART_RX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif
  localparam logic [31:0] A_DATA   = 32'h0000_0000;
  localparam logic [31:0] A_STATUS = 32'h0000_0004;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_uart_rx = 1'b1;
  logic        o_irq;
  logic        rd_req = 1'b0;
  logic        rd_gnt;
  logic [31:0] rd_addr = 32'h0;
  logic [31:0] rd_data;
  logic        wr_req = 1'b0;
  logic        wr_gnt;
  logic [31:0] wr_addr = 32'h0;
  logic [31:0] wr_data = 32'h0;
  logic [3:0]  wr_be = 4'h0;

  int total = 0;
  int bad   = 0;
  logic [7:0] sb [$];
  logic exp_ovr = 1'b0, exp_ferr = 1'b0, exp_perr = 1'b0;
  logic [31:0] obs;

  always #5 clk = ~clk;

  user_uart_rx #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .FIFO_DEPTH(16)) dut (
    .clk(clk), .rst(rst), .i_uart_rx(i_uart_rx), .o_irq(o_irq),
    .rd_req(rd_req), .rd_gnt(rd_gnt), .rd_addr(rd_addr), .rd_data(rd_data),
    .wr_req(wr_req), .wr_gnt(wr_gnt), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be)
  );

  task automatic check(input string tag, input logic [31:0] o, input logic [31:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, o, e);
    end
  endtask

  function automatic logic [31:0] exp_status();
    return {28'h0, exp_perr, exp_ferr, exp_ovr, (sb.size() != 0)};
  endfunction

  task automatic bus_read(input logic [31:0] addr, output logic [31:0] data);
    @(posedge clk); #1;
    rd_req = 1'b1; rd_addr = addr;
    #1 check("rd_gnt", {31'h0, rd_gnt}, 32'h1);
    @(posedge clk); #1;
    rd_req = 1'b0;
    data = rd_data;
  endtask

  task automatic bus_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] be);
    @(posedge clk); #1;
    wr_req = 1'b1; wr_addr = addr; wr_data = data; wr_be = be;
    #1 check("wr_gnt", {31'h0, wr_gnt}, 32'h1);
    @(posedge clk); #1;
    wr_req = 1'b0; wr_be = 4'h0;
  endtask

  task automatic check_status(input string tag);
    bus_read(A_STATUS, obs);
    check(tag, obs, exp_status());
  endtask

  task automatic check_data(input string tag);
    logic [31:0] e;
    bus_read(A_DATA, obs);
    if (sb.size() != 0) e = {23'h0, 1'b1, sb.pop_front()};
    else                e = 32'h0;
    check(tag, obs, e);
  endtask

  task automatic hold_bit(input logic v);
    i_uart_rx = v;
    repeat (BIT_DIV) @(posedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input logic par_bit);
    hold_bit(1'b0);
    for (int i = 0; i < 8; i++) hold_bit(b[i]);
    if (PAR_EN) hold_bit(par_bit);
    hold_bit(stop_bit);
    i_uart_rx = 1'b1;
  endtask

  // Well-formed frame; the model stores it or flags overflow when 16 are held.
  task automatic send_good(input logic [7:0] b);
    send_frame(b, 1'b1, ^b);
    if (sb.size() < 16) sb.push_back(b);
    else                exp_ovr = 1'b1;
  endtask

  initial begin
    repeat (5) @(posedge clk);
    #3 rst = 1'b0;
    repeat (5) @(posedge clk); #1;
    check("reset_irq", {31'h0, o_irq}, 32'h0);
    check("reset_rd_data", rd_data, 32'h0);
    check_status("reset_status");

    // 1: single byte
    send_good(8'hA5);
    repeat (10) @(posedge clk); #1;
    check("t1_irq", {31'h0, o_irq}, 32'h1);
    check_status("t1_status_full");
    check_data("t1_data");
    check_status("t1_status_empty");
    check("t1_irq_clear", {31'h0, o_irq}, 32'h0);

    // 2: short low pulse is a glitch
    i_uart_rx = 1'b0;
    repeat (100) @(posedge clk);
    i_uart_rx = 1'b1;
    repeat (BIT_DIV * 12) @(posedge clk); #1;
    check("t2_irq", {31'h0, o_irq}, 32'h0);
    check_status("t2_status");

    // 3: overflow with 17 bytes
    for (int i = 0; i < 17; i++) send_good(8'(i));
    repeat (10) @(posedge clk);
    check_status("t3_status_ovr");
    check_data("t3_first_data");
    bus_write(A_STATUS, 32'h2, 4'h1);
    exp_ovr = 1'b0;
    check_status("t3_status_clr");
    for (int i = 0; i < 15; i++) check_data("t3_drain");
    check_data("t3_empty_read");
    check_status("t3_status_end");

    // 4: framing error
    send_frame(8'h55, 1'b0, ^8'h55);
    exp_ferr = 1'b1;
    repeat (BIT_DIV * 3) @(posedge clk); #1;
    check("t4_irq", {31'h0, o_irq}, 32'h0);
    check_status("t4_status_ferr");
    bus_write(A_DATA, 32'h4, 4'hF);
    bus_write(A_STATUS, 32'h4, 4'h0);
    check_status("t4_status_no_be");
    bus_write(A_STATUS, 32'h4, 4'h1);
    exp_ferr = 1'b0;
    check_status("t4_status_clr");

    // 5: reset during data bit 4 of 0x3C
    hold_bit(1'b0);
    for (int i = 0; i < 4; i++) hold_bit(((8'h3C >> i) & 8'h01) != 8'h00);
    i_uart_rx = 1'b1;
    repeat (BIT_DIV / 2) @(posedge clk);
    #3 rst = 1'b1;
    repeat (5) @(posedge clk);
    #3 rst = 1'b0;
    sb.delete();
    exp_ovr = 1'b0; exp_ferr = 1'b0; exp_perr = 1'b0;
    repeat (2) @(posedge clk); #1;
    check("t5_rd_data_reset", rd_data, 32'h0);
    repeat (BIT_DIV * 12) @(posedge clk);
    check_status("t5_status_after_rst");
    send_good(8'h7E);
    repeat (10) @(posedge clk);
    check_status("t5_status_one");
    check_data("t5_data");
    check_status("t5_status_empty");

`ifdef USER_UART_RX_PARITY_EN
    // 6: parity error then good parity
    send_frame(8'h03, 1'b1, 1'b1);
    exp_perr = 1'b1;
    repeat (10) @(posedge clk);
    check_status("t6_status_perr");
    send_good(8'h03);
    repeat (10) @(posedge clk);
    check_status("t6_status_perr_data");
    check_data("t6_data");
    bus_write(A_STATUS, 32'h8, 4'h1);
    exp_perr = 1'b0;
    check_status("t6_status_clr");
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
